alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 61 ++++++
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared opcode map and state encoding for the ALU sequencer.
// The ALU opcodes are the cpu-wide constants understood by the external
// 4-bit ALU. The control opcodes are interpreted by the sequencer itself.
package alu_sequencer_pkg;

  // ALU opcodes (shared cpu opcode constants)
  localparam logic [5:0] OP_AND     = 6'h00;
  localparam logic [5:0] OP_OR      = 6'h01;
  localparam logic [5:0] OP_XOR     = 6'h02;
  localparam logic [5:0] OP_NOT_A   = 6'h03;
  localparam logic [5:0] OP_ADD_A_B = 6'h04;
  localparam logic [5:0] OP_INC_A   = 6'h05;
  localparam logic [5:0] OP_DEC_A   = 6'h06;
  localparam logic [5:0] OP_SHL_A   = 6'h07;
  localparam logic [5:0] OP_SHR_A   = 6'h08;
  localparam logic [5:0] OP_INC_B   = 6'h09;
  localparam logic [5:0] OP_DEC_B   = 6'h0A;
  localparam logic [5:0] OP_SHL_B   = 6'h0B;
  localparam logic [5:0] OP_SHR_B   = 6'h0C;

  // Control opcodes handled by the sequencer
  localparam logic [5:0] OP_LDA   = 6'h20;
  localparam logic [5:0] OP_LDB   = 6'h21;
  localparam logic [5:0] OP_MOVAB = 6'h22;
  localparam logic [5:0] OP_MOVBA = 6'h23;
  localparam logic [5:0] OP_JMP   = 6'h24;
  localparam logic [5:0] OP_JZ    = 6'h25;
  localparam logic [5:0] OP_JC    = 6'h26;
  localparam logic [5:0] OP_OUT   = 6'h27;
  localparam logic [5:0] OP_HALT  = 6'h28;
  localparam logic [5:0] OP_NOP   = 6'h29;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_OUT_WAIT = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  // Instruction word layout
  typedef struct packed {
    logic [5:0] opcode;
    logic [3:0] imm;
  } instr_t;

  // True for opcodes whose result comes from the external ALU
  function automatic logic is_alu_op(input logic [5:0] op);
    return op inside {OP_AND, OP_OR, OP_XOR, OP_NOT_A, OP_ADD_A_B,
                      OP_INC_A, OP_DEC_A, OP_SHL_A, OP_SHR_A,
                      OP_INC_B, OP_DEC_B, OP_SHL_B, OP_SHR_B};
  endfunction

  // True for unary ALU ops that read and write B instead of A
  function automatic logic is_b_unary(input logic [5:0] op);
    return op inside {OP_INC_B, OP_DEC_B, OP_SHL_B, OP_SHR_B};
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Tiny accumulator-style sequencer: fetches 10-bit instructions from a
// synchronous ROM, drives an external 4-bit ALU, keeps A/B/zf/cf and
// presents OUT values on a valid/ready port.
//
// Output handshake: out_valid rises with out_data at the edge that executes
// OUT; out_valid and out_data then stay stable until an edge where both
// out_valid and out_ready are high, which is the transfer edge. out_valid
// is cleared at that edge. Reset discards a pending transfer immediately.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] instr_addr,
  input  logic [9:0] instr_data,
  output logic [5:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_r,
  input  logic       alu_zf,
  input  logic       alu_cf,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       halted,
  output logic       zf,
  output logic       cf,
  output logic [2:0] dbg_state,
  output logic [3:0] dbg_a,
  output logic [3:0] dbg_b
);

  state_t     state, state_next;
  logic [3:0] pc, pc_next, pc_inc;
  instr_t     ir, ir_next;
  logic [3:0] a, a_next;
  logic [3:0] b, b_next;
  logic       zf_next, cf_next;
  logic [3:0] out_data_next;
  logic       out_valid_next;

  // pc wraps naturally from 15 to 0 in 4 bits
  assign pc_inc     = pc + 4'd1;
  assign instr_addr = pc;
  assign halted     = (state == S_HALT);
  assign dbg_state  = state;
  assign dbg_a      = a;
  assign dbg_b      = b;

  // Next-state and datapath decisions; everything holds unless changed
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    ir_next        = ir;
    a_next         = a;
    b_next         = b;
    zf_next        = zf;
    cf_next        = cf;
    out_data_next  = out_data;
    out_valid_next = out_valid;
    alu_opcode     = 6'd0;
    alu_a          = 4'd0;
    alu_b          = 4'd0;

    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        // ROM samples instr_addr at this edge; data arrives in DECODE
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ir_next    = instr_t'(instr_data);
        state_next = S_EXEC;
      end
      S_EXEC: begin
        alu_opcode = ir.opcode;
        alu_a      = is_b_unary(ir.opcode) ? b : a;
        alu_b      = b;
        state_next = S_FETCH;
        pc_next    = pc_inc;
        if (is_alu_op(ir.opcode)) begin
          if (is_b_unary(ir.opcode)) b_next = alu_r;
          else                       a_next = alu_r;
          zf_next = alu_zf;
          cf_next = alu_cf;
        end else begin
          case (ir.opcode)
            OP_LDA:   a_next = ir.imm;
            OP_LDB:   b_next = ir.imm;
            OP_MOVAB: b_next = a;
            OP_MOVBA: a_next = b;
            OP_JMP:   pc_next = ir.imm;
            OP_JZ:    if (zf) pc_next = ir.imm;
            OP_JC:    if (cf) pc_next = ir.imm;
            OP_OUT: begin
              out_data_next  = a;
              out_valid_next = 1'b1;
              pc_next        = pc;
              state_next     = S_OUT_WAIT;
            end
            OP_HALT: begin
              pc_next    = pc;
              state_next = S_HALT;
            end
            // NOP and undefined opcodes only advance pc
            default: ;
          endcase
        end
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          pc_next        = pc_inc;
          state_next     = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_next = S_IDLE;
    endcase
  end

  // Architectural and control registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= 4'd0;
      ir        <= '0;
      a         <= 4'd0;
      b         <= 4'd0;
      zf        <= 1'b0;
      cf        <= 1'b0;
      out_data  <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      ir        <= ir_next;
      a         <= a_next;
      b         <= b_next;
      zf        <= zf_next;
      cf        <= cf_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
    end
  end

endmodule
